// File: rtl/relu_maxpool2_if.sv
// relu_maxpool2_if: input stream, output stream and frame control/status
// signals of the ReLU + 2x2 max-pool stage.
interface relu_maxpool2_if #(
  parameter int N = 35,
  parameter int C = 8
) ();
  localparam int CHW = (C > 1) ? $clog2(C) : 1;

  logic           go;
  logic           busy;
  logic           flag;

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;

  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_data;
  logic [CHW-1:0] out_ch;
  logic           out_last;

  // Producer/consumer side that drives the stage.
  modport master (
    output go, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last, busy, flag
  );

  // The stage itself.
  modport slave (
    input  go, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last, busy, flag
  );
endinterface

// File: rtl/relu_maxpool2.sv
// relu_maxpool2: streaming ReLU followed by 2x2/stride-2 max-pool over a
// C-channel WxW sign-magnitude feature map in channel-major raster order.
// A half-row line buffer carries the even-row partial maxima to the odd row.
module relu_maxpool2 #(
  parameter int N = 35,
  parameter int W = 32,
  parameter int C = 8
) (
  input  logic             clk,
  input  logic             rst,
  relu_maxpool2_if.slave   bus
);
  localparam int CLW = $clog2(W);
  localparam int CHW = (C > 1) ? $clog2(C) : 1;
  localparam int HW  = W / 2;
  localparam logic [CLW-1:0] POS_MAX = CLW'(W - 1);
  localparam logic [CHW-1:0] CH_MAX  = CHW'(C - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CLW-1:0] col_q, col_d;
  logic [CLW-1:0] row_q, row_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [N-1:0]   hold_q, hold_d;
  logic [N-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic [CHW-1:0] out_ch_q, out_ch_d;
  logic           out_last_q, out_last_d;

  logic [N-1:0]   lb_q [HW];
  logic           lb_we;
  logic [CLW-2:0] lb_idx;
  logic [N-1:0]   lb_wdata;

  logic           in_ready;
  logic           accept;
  logic           last_px;
  logic [N-1:0]   pix_r;

  // Larger magnitude wins; on equal magnitudes the first operand is kept.
  function automatic logic [N-1:0] mag_max(input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    return (a[N-2:0] >= b[N-2:0]) ? a : b;
  endfunction

  // Handshake qualifiers, ReLU and frame-position decode.
  assign in_ready = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign pix_r    = bus.in_data[N-1] ? '0 : bus.in_data;
  assign lb_idx   = col_q[CLW-1:1];
  assign last_px  = (col_q == POS_MAX) && (row_q == POS_MAX) && (ch_q == CH_MAX);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.flag      = (state_q == S_DONE);

  // Frame FSM and raster position counters (advance only on accept).
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
          ch_d    = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (col_q == POS_MAX) begin
            col_d = '0;
            if (row_q == POS_MAX) begin
              row_d = '0;
              ch_d  = (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
          if (last_px) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || bus.out_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pooling datapath: hold register, line-buffer write and output register.
  always_comb begin
    hold_d      = hold_q;
    lb_we       = 1'b0;
    lb_wdata    = mag_max(hold_q, pix_r);
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    if (accept) begin
      case ({row_q[0], col_q[0]})
        2'b00: hold_d = pix_r;
        2'b01: lb_we  = 1'b1;
        2'b10: hold_d = mag_max(lb_q[lb_idx], pix_r);
        default: begin
          out_data_d  = mag_max(hold_q, pix_r);
          out_valid_d = 1'b1;
          out_ch_d    = ch_q;
          out_last_d  = last_px;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ch_q        <= ch_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
    end
  end

  // Half-row line buffer of even-row partial maxima.
  always_ff @(posedge clk) begin
    // NOTE: no reset on the buffer; each entry is written on an even row before
    // the odd row reads it, so stale contents are never observed.
    if (lb_we) lb_q[lb_idx] <= lb_wdata;
  end
endmodule

// File: doc/relu_maxpool2.md
# relu_maxpool2

Streaming ReLU + 2x2/stride-2 max-pool stage that sits directly downstream of the second convolution stage. It consumes that stage's 8-channel 32x32 feature map one 35-bit sign-magnitude Q32 word per cycle, in channel-major raster order. It emits an 8-channel 16x16 map in the same order to the next layer. A single half-row line buffer holds partial maxima, so the block never stores a full feature map.

## Interface
- N, 35: data word width; sign-magnitude, bit N-1 = sign, Q32 fraction
- W, 32: input map height and width; must be even
- C, 8: channels per frame
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- go  in  1  start-of-frame strobe; sampled in IDLE only
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  N  input pixel
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  N  pooled pixel, always non-negative (bit N-1 = 0)
- out_ch  out  $clog2(C)  channel index of out_data
- out_last  out  1  high with the final pooled pixel of the frame
- busy  out  1  high in RUN or DRAIN
- flag  out  1  one-cycle done pulse

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on go: clears the col, row and ch counters.
  - RUN -> DRAIN on acceptance of the last input (col=W-1, row=W-1, ch=C-1).
  - DRAIN -> DONE when the output register is empty, or is handshaken that cycle.
  - DONE -> IDLE unconditionally. flag=1 only in DONE.
  - go outside IDLE is ignored.
- **Input accept:** in_valid && in_ready. in_ready = (state==RUN) && (!out_valid || out_ready).
- **ReLU:** r = in_data[N-1] ? 0 : in_data. Negative zero maps to 0.
- **Comparison:** max(a,b) compares magnitudes unsigned on bits N-2:0. Ties keep a.
- **Per accepted pixel** at (row, col), with k = col>>1:
  - even row, even col: hold <= r
  - even row, odd col: lb[k] <= max(hold, r)
  - odd row, even col: hold <= max(lb[k], r)
  - odd row, odd col: out_data <= max(hold, r); out_valid <= 1; out_ch <= ch; out_last <= (row==W-1 && col==W-1 && ch==C-1)
- **Counters:** col wraps W-1 -> 0 and increments row. row wraps W-1 -> 0 and increments ch. ch wraps after C-1 (frame end).
- **Line buffer:** W/2 x N bits. It is not cleared between channels, because every entry is rewritten on an even row before it is read.
- **Output register:** out_valid clears on a handshake unless it is reloaded in the same cycle. A simultaneous handshake and new pool result loads the new value with out_valid staying 1.
- **Reset mid-frame:** abandons the frame; no flag is produced.

## Timing
- **Reset values:** state=IDLE, in_ready=0, out_valid=0, out_data=0, out_ch=0, out_last=0, busy=0, flag=0, all counters=0.
- **Latency:** out_valid rises the cycle after the odd-row/odd-col input is accepted (1 cycle).
- **Throughput:** 1 input/cycle with out_ready held high. A frame takes C·W·W input cycles.
- **Stall:** out_valid && !out_ready forces in_ready=0. out_data, out_ch and out_last hold stable until the handshake.
- **flag timing:** flag rises exactly 1 cycle after the out_last handshake, or the cycle after entering DRAIN if that handshake coincided with the last input. busy falls in the same cycle flag rises.
- **Input hold:** in_data is don't-care when in_valid=0. Counters advance only on accept.

## Test plan
- **Ramp:** W=4, C=1, in_data = raster index 0..15, out_ready=1 -> outputs 5, 7, 13, 15 in order. out_last on 15. flag pulse 1 cycle after.
- **ReLU:** all inputs sign-magnitude -5 (bit34=1, magnitude 5), except one 0x0_0000_0003 in each 2x2 block -> every output = 3. A block of all-negative inputs -> 0. A negative-zero input -> 0.
- **Backpressure:** default W=32, C=8 random data, out_ready toggling 50% -> 2048 outputs matching the reference model. No output dropped or duplicated. out_data stable while stalled.
- **Channel tagging:** channel c filled with constant c+1 -> 256 outputs per channel equal to c+1 with out_ch=c. out_last only on output 2048.
- **go handling:** go pulsed during RUN -> ignored, counters undisturbed. go in IDLE after DONE -> second frame processed identically.
- **Reset mid-frame:** assert reset after 700 inputs -> all outputs return to reset values immediately. No flag. A new frame after go produces correct results.
